// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Covers the FSM state encoding, the latched request payload and the address error check.
package dmem_pkg;

   localparam int unsigned DATA_W      = 64;
   localparam int unsigned ADDR_W      = 64;
   localparam int unsigned DWORD_BYTES = 8;
   localparam int unsigned ADDR_LSB    = $clog2(DWORD_BYTES);
   localparam int unsigned IDX_FULL_W  = ADDR_W - ADDR_LSB;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Misaligned, or doubleword index beyond the array; full-width compare so high addresses never wrap.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
      logic [IDX_FULL_W-1:0] idx;
      idx = addr[ADDR_W-1:ADDR_LSB];
      return (addr[ADDR_LSB-1:0] != '0) || (idx >= IDX_FULL_W'(depth));
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU and the data-memory responder.
// Both the request and the response channel use valid/ready.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Doubleword storage for the responder: synchronous write and combinational read.
// Both share a single index port. The array has no reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle LDUR/STUR responder with a fixed access latency and one transaction in flight.
// The array is decoded and accessed on the single edge that enters RESP.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_responder_if.slave mem_if
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam bit          DIRECT = (LATENCY == 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of two >= 2");
   end
   if (LATENCY < 1) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be >= 1");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;

   req_t              req_in_c;
   req_t              req_cur_c;
   logic              enter_resp_c;
   logic              dec_err_c;
   logic              arr_we_c;
   logic [IDX_W-1:0]  arr_idx_c;
   logic [DATA_W-1:0] arr_rdata_c;

   // With LATENCY=1 the RESP entry edge is the acceptance edge, so decode the live request there.
   always_comb begin
      req_in_c  = '{write: mem_if.req_write, addr: mem_if.req_addr, wdata: mem_if.req_wdata};
      req_cur_c = (state_q == IDLE) ? req_in_c : req_q;
      dec_err_c = addr_err(req_cur_c.addr, DEPTH);
      arr_idx_c = req_cur_c.addr[ADDR_LSB +: IDX_W];
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we_c),
      .idx_i   (arr_idx_c),
      .wdata_i (req_cur_c.wdata),
      .rdata_o (arr_rdata_c)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      req_ready_d  = req_ready_q;
      rsp_valid_d  = rsp_valid_q;
      enter_resp_c = 1'b0;
      arr_we_c     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mem_if.req_valid) begin
               req_d       = req_in_c;
               req_ready_d = 1'b0;
               if (DIRECT) begin
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               enter_resp_c = 1'b1;
            end
         end
         RESP: begin
            if (mem_if.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rdata_d     = '0;
               err_d       = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Stores commit here; a reset on the same edge suppresses the write.
      if (enter_resp_c) begin
         state_d     = RESP;
         rsp_valid_d = 1'b1;
         err_d       = dec_err_c;
         rdata_d     = (!dec_err_c && !req_cur_c.write) ? arr_rdata_c : '0;
         arr_we_c    = rst_n && !dec_err_c && req_cur_c.write;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign mem_if.req_ready = req_ready_q;
   assign mem_if.rsp_valid = rsp_valid_q;
   assign mem_if.rsp_rdata = rdata_q;
   assign mem_if.rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the CPU's load/store port. It answers doubleword LDUR/STUR requests with a valid/ready handshake on the request and response channels and a fixed, parameterised access latency. It replaces the zero-latency combinational data memory, which lets the datapath be verified against realistic memory stalls. It holds one outstanding transaction at a time.

## Interface
- DEPTH, 128: number of 64-bit doublewords stored; power of two, at least 2.
- LATENCY, 2: cycles from request acceptance to first response-valid; at least 1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store (STUR), 0 = load (LDUR).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  64  load data; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0. Array contents are not reset.
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid, latch write, addr and wdata, then go to BUSY with cnt=LATENCY-1. If LATENCY=1, go straight to RESP instead.
- BUSY: req_ready=0. Decrement cnt each cycle. When cnt==1 at an edge, move to RESP.
- Entering RESP (a single edge):
  - Decode the latched address: idx = addr[63:3]. Set err = (addr[2:0]!=0) or (idx >= DEPTH).
  - Load, no error: rsp_rdata = mem[idx].
  - Store, no error: write mem[idx] = wdata; rsp_rdata = 0.
  - Error: no array access, rsp_rdata = 0, rsp_err = 1.
- RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err hold stable until the response handshake. On rsp_ready, go to IDLE with rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Stores are acknowledged: every accepted request produces exactly one response.
- A store commits at the RESP entry edge. A load issued after that store's response completes sees the new value.

## Timing
- Request accepted at edge E (req_valid & req_ready). rsp_valid first goes high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Response consumed at edge F (rsp_valid & rsp_ready). req_ready is high in the cycle after F. There is no same-cycle turnaround.
- Maximum throughput is one transaction per LATENCY+1 cycles when rsp_ready is held high.
- rsp_ready low stalls RESP indefinitely. Outputs do not change while stalled.
- req_valid while req_ready=0 is ignored and not queued. The requester must hold the request.
- Reset wins over everything. rst_n low at any edge forces the reset values.
  - A store still in BUSY is dropped and the array is unchanged.
  - A store already committed at the RESP entry edge stays committed.
- Address arithmetic is unsigned 64-bit. The out-of-range check uses the full idx, with no truncation or wrap.

## Structure
- Package dmem_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - DWORD_BYTES = 8 and ADDR_LSB = 3;
  - a request struct {write, addr, wdata}.
- Sub-module dmem_array: DEPTH×64 storage with synchronous write, combinational read and an index port. It has no reset. The FSM, counter and error check live in the top level.

## Test plan
- Store then load, LATENCY=2: store addr 0x10 with data 0xDEAD_BEEF_0000_0001 gives rsp_valid 2 cycles after acceptance, err=0, rdata=0. Load addr 0x10 then returns 0xDEAD_BEEF_0000_0001.
- Misaligned and out-of-range requests, DEPTH=128:
  - A load at 0x0C returns err=1, rdata=0.
  - A store at 0x400 (idx 128) returns err=1, and a later load at 0x3F8 still holds its prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid, rdata and err stay stable. req_ready stays 0, and a req_valid pulse in that window produces no extra response.
- Back-to-back loads with rsp_ready tied to 1 and LATENCY=3: responses are spaced exactly 4 cycles apart, and req_ready is high for one cycle after each response.
- Reset mid-store: accept a store of 0x55 to 0x20 with LATENCY=4 and assert rst_n=0 during BUSY. All outputs take their reset values next cycle. A following load at 0x20 returns the old contents.
- LATENCY=1: a load is accepted at edge E and rsp_valid is high in the next cycle, with correct data.
